// File: rtl/jk_bank_pkg.sv
// Shared types for the JK bank arbiter: command opcodes, FSM states and
// the opcode-to-{J,K} decode.
package jk_bank_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    APPLY = 2'b01,
    RESP  = 2'b10
  } state_e;

  function automatic logic [1:0] op_to_jk(input jk_op_e op);
    logic [1:0] jk;
    case (op)
      CLR:     jk = 2'b01;
      SET:     jk = 2'b10;
      TGL:     jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK flip-flops, each with an asynchronous active-low clear.
module jk_ff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // JK characteristic equation: Q+ = J & ~Q | ~K & Q
  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK flip-flop bank between two command
// requesters; each command runs IDLE -> APPLY -> RESP.
//
//   state | meaning
//   IDLE  | offer req_ready to the arbitration winner, latch command on accept
//   APPLY | drive j_bus/k_bus from latched op/mask for one cycle
//   RESP  | present rsp_valid/rsp_id/rsp_q until rsp_ready
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][1:0]       req_op,
  input  logic [1:0][WIDTH-1:0] req_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_q,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      j_bus,
  output logic [WIDTH-1:0]      k_bus
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  jk_op_e           op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             id_q, id_d;
  logic             grant;
  logic [1:0]       jk;

  // With both valid the requester that did not win last time goes next;
  // a lone requester wins outright.
  always_comb begin
    if (&req_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req_valid[1];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    mask_d       = mask_q;
    id_d         = id_q;
    req_ready    = '0;
    j_bus        = '0;
    k_bus        = '0;
    rsp_valid    = 1'b0;
    rsp_id       = 1'b0;
    rsp_q        = '0;
    jk           = op_to_jk(op_q);

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          op_d             = jk_op_e'(req_op[grant]);
          mask_d           = req_mask[grant];
          id_d             = grant;
          last_grant_d     = grant;
          state_d          = APPLY;
        end
      end
      APPLY: begin
        j_bus   = jk[1] ? mask_q : '0;
        k_bus   = jk[0] ? mask_q : '0;
        state_d = RESP;
      end
      RESP: begin
        // Bank is held in RESP, so q is stable for the whole response.
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_q     = q;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= HOLD;
      mask_q       <= '0;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      mask_q       <= mask_d;
      id_q         <= id_d;
    end
  end

  jk_ff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .j       (j_bus),
    .k       (k_bus),
    .q       (q)
  );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: expected responses are queued on
// accept from a bench-side JK model and compared when rsp_valid appears.
module tb_jk_bank_arbiter;

  localparam int W = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][1:0]     req_op;
  logic [1:0][W-1:0]   req_mask;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [W-1:0]        rsp_q;
  logic [W-1:0]        q;
  logic [W-1:0]        j_bus;
  logic [W-1:0]        k_bus;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] q;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model_q;

  jk_bank_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_mask  (req_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .q         (q),
    .j_bus     (j_bus),
    .k_bus     (k_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_apply(input logic [W-1:0] cur,
                                               input logic [1:0] op,
                                               input logic [W-1:0] m);
    logic [W-1:0] r;
    r = cur;
    for (int b = 0; b < W; b++) begin
      if (m[b]) begin
        case (op)
          2'b01:   r[b] = 1'b0;
          2'b10:   r[b] = 1'b1;
          2'b11:   r[b] = ~cur[b];
          default: r[b] = cur[b];
        endcase
      end
    end
    return r;
  endfunction

  task automatic push_exp(input logic id, input logic [1:0] op, input logic [W-1:0] m);
    exp_t e;
    model_q = model_apply(model_q, op, m);
    e.id = id;
    e.q  = model_q;
    sb.push_back(e);
  endtask

  // Raise one request and hold it until accepted; returns at APPLY (posedge+1).
  task automatic drive_cmd(input int id, input logic [1:0] op, input logic [W-1:0] m,
                           output bit ok);
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    req_mask[id]  = m;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        push_exp(1'(id), op, m);
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    req_valid[id] = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid; returns at the negedge where it is seen.
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_mask  = '0;
    rsp_ready = 1'b1;
    model_q   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_id, rsp_q, q, j_bus, k_bus} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: ready=%b rv=%b id=%b rq=%b q=%b j=%b k=%b, required all zero",
                 i, req_ready, rsp_valid, rsp_id, rsp_q, q, j_bus, k_bus);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_set();
    bit   ok;
    exp_t e;
    drive_cmd(0, 2'b10, 4'b0101, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_set_accept: not accepted within budget");
    end
    @(negedge clk);
    checks++;
    if (j_bus !== 4'b0101 || k_bus !== 4'b0000 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_set_jk: j=%b k=%b rv=%b, required j=0101 k=0000 rv=0",
               j_bus, k_bus, rsp_valid);
    end
    wait_rsp(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL single_set_rsp: no response (ok=%0d queued=%0d)", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if (rsp_id !== e.id || rsp_q !== e.q) begin
        errors++;
        $display("FAIL single_set_rsp: id=%b q=%b, required id=%b q=%b", rsp_id, rsp_q, e.id, e.q);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_toggle_clear();
    bit         ok;
    exp_t       e;
    logic [1:0] ops[2];
    logic [W-1:0] masks[2];
    ops[0] = 2'b11; masks[0] = 4'b1111;
    ops[1] = 2'b01; masks[1] = 4'b0010;
    for (int n = 0; n < 2; n++) begin
      drive_cmd(1, ops[n], masks[n], ok);
      wait_rsp(ok);
      checks++;
      if (!ok || sb.size() == 0) begin
        errors++;
        $display("FAIL toggle_clear_rsp%0d: no response (ok=%0d queued=%0d)", n, ok, sb.size());
      end else begin
        e = sb.pop_front();
        if (rsp_id !== e.id || rsp_q !== e.q || q !== e.q) begin
          errors++;
          $display("FAIL toggle_clear_rsp%0d: id=%b rsp_q=%b q=%b, required id=%b q=%b",
                   n, rsp_id, rsp_q, q, e.id, e.q);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fairness();
    int   grants;
    logic exp_grant;
    logic g;
    exp_t e;
    grants    = 0;
    exp_grant = 1'b0;
    req_op    = '0;
    req_mask  = {4'b1111, 4'b1111};
    req_valid = 2'b11;
    for (int c = 0; c < 60 && (grants < 4 || sb.size() > 0); c++) begin
      @(negedge clk);
      checks++;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL fair_onehot: req_ready=%b, required at most one bit", req_ready);
      end
      if (req_ready != 2'b00) begin
        g = req_ready[1];
        checks++;
        if (g !== exp_grant) begin
          errors++;
          $display("FAIL fair_order grant %0d: got %b, required %b", grants, g, exp_grant);
        end
        exp_grant = ~exp_grant;
        push_exp(g, 2'b00, 4'b1111);
        grants++;
      end
      if (rsp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL fair_rsp: unexpected response id=%b q=%b", rsp_id, rsp_q);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_q !== e.q) begin
            errors++;
            $display("FAIL fair_rsp: id=%b q=%b, required id=%b q=%b", rsp_id, rsp_q, e.id, e.q);
          end
        end
      end
      @(posedge clk);
      #1;
      if (grants == 4) req_valid = 2'b00;
    end
    req_valid = 2'b00;
    checks++;
    if (grants != 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL fair_done: grants=%0d pending=%0d, required 4 and 0", grants, sb.size());
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    exp_t e;
    rsp_ready = 1'b0;
    drive_cmd(0, 2'b10, 4'b0011, ok);
    req_op[1]    = 2'b00;
    req_mask[1]  = 4'b0000;
    req_valid[1] = 1'b1;
    wait_rsp(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL bp_rsp: no response (ok=%0d queued=%0d)", ok, sb.size());
    end else begin
      e = sb[0];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin
          @(posedge clk);
          #1;
          @(negedge clk);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_q !== e.q || req_ready !== 2'b00) begin
          errors++;
          $display("FAIL bp_stall cycle %0d: rv=%b id=%b q=%b ready=%b, required rv=1 id=%b q=%b ready=00",
                   i, rsp_valid, rsp_id, rsp_q, req_ready, e.id, e.q);
        end
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_q !== e.q || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_release: rv=%b id=%b q=%b ready=%b, required rv=1 id=%b q=%b ready=00",
                 rsp_valid, rsp_id, rsp_q, req_ready, e.id, e.q);
      end
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_resume: req_ready=%b, required 10", req_ready);
    end
    if (req_ready[1]) push_exp(1'b1, 2'b00, 4'b0000);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL bp_next_rsp: no response (ok=%0d queued=%0d)", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if (rsp_id !== e.id || rsp_q !== e.q) begin
        errors++;
        $display("FAIL bp_next_rsp: id=%b q=%b, required id=%b q=%b", rsp_id, rsp_q, e.id, e.q);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    bit   ok;
    exp_t e;
    rsp_ready = 1'b1;
    drive_cmd(0, 2'b10, 4'b1111, ok);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (q !== '0 || j_bus !== '0 || k_bus !== '0 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL midreset_clear: q=%b j=%b k=%b rv=%b ready=%b, required all zero",
               q, j_bus, k_bus, rsp_valid, req_ready);
    end
    sb.delete();
    model_q = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || q !== '0) begin
        errors++;
        $display("FAIL midreset_norsp cycle %0d: rv=%b q=%b, required rv=0 q=0000", i, rsp_valid, q);
      end
    end
    @(posedge clk);
    #1;
    req_op    = '0;
    req_mask  = '0;
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL midreset_first_grant: req_ready=%b, required 01", req_ready);
    end
    if (req_ready != 2'b00) push_exp(req_ready[1], 2'b00, 4'b0000);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_rsp(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL midreset_rsp: no response (ok=%0d queued=%0d)", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if (rsp_id !== 1'b0 || rsp_id !== e.id || rsp_q !== e.q) begin
        errors++;
        $display("FAIL midreset_rsp: id=%b q=%b, required id=0 q=%b", rsp_id, rsp_q, e.q);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_toggle_clear();
    test_fairness();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
